// File: rtl/frame_buf_scheduler.sv
// frame_buf_scheduler: rotates four frame buffers between one writer and two
// readers. Ownership changes only on vsync rising edges; the writer never
// picks a buffer that either reader will own after this edge, nor the frame it
// just completed. Base addresses are registered from the next-state indices,
// so each base moves on the same clock edge as its index.
// Optional feature macro: FBS_DROP_CNT_EN enables the unread-frame drop
// counter. When it is undefined, drop_cnt is tied to zero.
module frame_buf_scheduler #(
    parameter int                   ADDR_BITS = 25,
    parameter logic [ADDR_BITS-1:0] BASE_0    = '0,
    parameter logic [ADDR_BITS-1:0] BASE_1    = '0,
    parameter logic [ADDR_BITS-1:0] BASE_2    = '0,
    parameter logic [ADDR_BITS-1:0] BASE_3    = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 write_vs,
    input  logic                 read_0_vs,
    input  logic                 read_1_vs,
    output logic [1:0]           write_idx,
    output logic [1:0]           read_0_idx,
    output logic [1:0]           read_1_idx,
    output logic [1:0]           latest_idx,
    output logic                 latest_valid,
    output logic [ADDR_BITS-1:0] write_base,
    output logic [ADDR_BITS-1:0] read_0_base,
    output logic [ADDR_BITS-1:0] read_1_base,
    output logic [15:0]          drop_cnt
);

    logic       write_vs_d, read_0_vs_d, read_1_vs_d;
    logic       write_edge, read_0_edge, read_1_edge;
    logic [1:0] write_nxt, read_0_nxt, read_1_nxt, latest_nxt;

    function automatic logic [ADDR_BITS-1:0] base_of(input logic [1:0] idx);
        case (idx)
            2'd0:    base_of = BASE_0;
            2'd1:    base_of = BASE_1;
            2'd2:    base_of = BASE_2;
            default: base_of = BASE_3;
        endcase
    endfunction

    // Edge detection and next-state ownership for all four indices.
    always_comb begin
        write_edge  = write_vs  & ~write_vs_d  & enable;
        read_0_edge = read_0_vs & ~read_0_vs_d & enable;
        read_1_edge = read_1_vs & ~read_1_vs_d & enable;

        // A write edge publishes the buffer the writer just finished.
        latest_nxt = write_edge ? write_idx : latest_idx;

        // Readers take the newest frame, including one completed this cycle.
        read_0_nxt = read_0_idx;
        if (read_0_edge && (latest_valid || write_edge)) begin
            read_0_nxt = latest_nxt;
        end
        read_1_nxt = read_1_idx;
        if (read_1_edge && (latest_valid || write_edge)) begin
            read_1_nxt = latest_nxt;
        end

        // Lowest index not held by the old writer frame or either reader's
        // next buffer; with four buffers and three owners one is always free.
        write_nxt = write_idx;
        if (write_edge) begin
            for (int i = 3; i >= 0; i--) begin
                if (2'(i) != write_idx && 2'(i) != read_0_nxt && 2'(i) != read_1_nxt) begin
                    write_nxt = 2'(i);
                end
            end
        end
    end

    // Ownership, latest-frame and base-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_vs_d   <= 1'b0;
            read_0_vs_d  <= 1'b0;
            read_1_vs_d  <= 1'b0;
            write_idx    <= 2'd1;
            read_0_idx   <= 2'd0;
            read_1_idx   <= 2'd0;
            latest_idx   <= 2'd0;
            latest_valid <= 1'b0;
            write_base   <= BASE_1;
            read_0_base  <= BASE_0;
            read_1_base  <= BASE_0;
        end else begin
            // Delayed vsync tracks even while disabled, so re-enabling with
            // vsync already high does not fabricate an edge.
            write_vs_d  <= write_vs;
            read_0_vs_d <= read_0_vs;
            read_1_vs_d <= read_1_vs;
            write_idx   <= write_nxt;
            read_0_idx  <= read_0_nxt;
            read_1_idx  <= read_1_nxt;
            latest_idx  <= latest_nxt;
            if (write_edge) begin
                latest_valid <= 1'b1;
            end
            write_base  <= enable ? base_of(write_nxt)  : BASE_0;
            read_0_base <= enable ? base_of(read_0_nxt) : BASE_0;
            read_1_base <= enable ? base_of(read_1_nxt) : BASE_0;
        end
    end

`ifdef FBS_DROP_CNT_EN
    logic latest_unread;
    logic any_read_edge;

    assign any_read_edge = read_0_edge | read_1_edge;

    // Track whether the newest frame has been taken, and count frames that
    // were replaced before any reader picked them up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latest_unread <= 1'b0;
            drop_cnt      <= 16'd0;
        end else if (write_edge) begin
            if (latest_unread && !any_read_edge && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            latest_unread <= ~any_read_edge;
        end else if (any_read_edge && latest_valid) begin
            latest_unread <= 1'b0;
        end
    end
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// tb_frame_buf_scheduler: directed scenarios plus randomized vsync traffic,
// compared every cycle against an ownership-table reference model.
module tb_frame_buf_scheduler;

    localparam int         AW = 25;
    localparam logic [24:0] B0 = 25'h000_1000;
    localparam logic [24:0] B1 = 25'h020_0000;
    localparam logic [24:0] B2 = 25'h040_0000;
    localparam logic [24:0] B3 = 25'h060_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          write_vs = 1'b0, read_0_vs = 1'b0, read_1_vs = 1'b0;
    logic [1:0]    write_idx, read_0_idx, read_1_idx, latest_idx;
    logic          latest_valid;
    logic [AW-1:0] write_base, read_0_base, read_1_base;
    logic [15:0]   drop_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int n_forced = 0;

    frame_buf_scheduler #(
        .ADDR_BITS(AW), .BASE_0(B0), .BASE_1(B1), .BASE_2(B2), .BASE_3(B3)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .write_vs(write_vs), .read_0_vs(read_0_vs), .read_1_vs(read_1_vs),
        .write_idx(write_idx), .read_0_idx(read_0_idx), .read_1_idx(read_1_idx),
        .latest_idx(latest_idx), .latest_valid(latest_valid),
        .write_base(write_base), .read_0_base(read_0_base), .read_1_base(read_1_base),
        .drop_cnt(drop_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: who owns which buffer, plus the newest complete frame
    int       m_owner_w, m_owner_r[2], m_latest, m_drops;
    bit       m_valid, m_unread;
    bit       m_prev_w, m_prev_r[2];
    logic [AW-1:0] m_wb, m_rb[2];

    function automatic logic [AW-1:0] addr_of(input int b);
        logic [AW-1:0] tab [4];
        tab[0] = B0; tab[1] = B1; tab[2] = B2; tab[3] = B3;
        return tab[b];
    endfunction

    task automatic model_reset();
        m_owner_w = 1; m_owner_r[0] = 0; m_owner_r[1] = 0;
        m_latest = 0; m_valid = 0; m_unread = 0; m_drops = 0;
        m_prev_w = 0; m_prev_r[0] = 0; m_prev_r[1] = 0;
        m_wb = B1; m_rb[0] = B0; m_rb[1] = B0;
    endtask

    // one clock of the model, using the levels the DUT sampled
    task automatic model_step();
        bit we, re[2], any_re, took;
        bit busy [4];
        int busy_n;
        we    = enable && write_vs && !m_prev_w;
        re[0] = enable && read_0_vs && !m_prev_r[0];
        re[1] = enable && read_1_vs && !m_prev_r[1];
        m_prev_w = write_vs; m_prev_r[0] = read_0_vs; m_prev_r[1] = read_1_vs;
        any_re = re[0] || re[1];
        took   = any_re && (m_valid || we);
        if (we) begin
            if (m_unread && !any_re && m_drops < 65535) m_drops++;
        end
        if (we) begin
            m_latest = m_owner_w;
            m_valid  = 1;
            m_unread = !any_re;
        end else if (took) begin
            m_unread = 0;
        end
        for (int k = 0; k < 2; k++) if (re[k] && m_valid) m_owner_r[k] = m_latest;
        if (we) begin
            foreach (busy[b]) busy[b] = 0;
            busy[m_latest] = 1; busy[m_owner_r[0]] = 1; busy[m_owner_r[1]] = 1;
            busy_n = 0;
            foreach (busy[b]) busy_n += int'(busy[b]);
            if (busy_n == 3) n_forced++;
            for (int b = 3; b >= 0; b--) if (!busy[b]) m_owner_w = b;
        end
        m_wb    = enable ? addr_of(m_owner_w)    : B0;
        m_rb[0] = enable ? addr_of(m_owner_r[0]) : B0;
        m_rb[1] = enable ? addr_of(m_owner_r[1]) : B0;
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        string       nm [9];
        int          exp_drop;
        nm = '{"write_idx", "read_0_idx", "read_1_idx", "latest_idx", "latest_valid",
               "write_base", "read_0_base", "read_1_base", "drop_cnt"};
`ifdef FBS_DROP_CNT_EN
        exp_drop = m_drops;
`else
        exp_drop = 0;
`endif
        exp_q = {32'(m_owner_w), 32'(m_owner_r[0]), 32'(m_owner_r[1]), 32'(m_latest),
                 32'(m_valid), 32'(m_wb), 32'(m_rb[0]), 32'(m_rb[1]), 32'(exp_drop)};
        got_q = {32'(write_idx), 32'(read_0_idx), 32'(read_1_idx), 32'(latest_idx),
                 32'(latest_valid), 32'(write_base), 32'(read_0_base), 32'(read_1_base),
                 32'(drop_cnt)};
        for (int i = 0; i < 9; i++) check({tag, ".", nm[i]}, got_q.pop_front(), exp_q.pop_front());
    endtask

    // driver: apply levels at the falling edge, check after the next rising edge
    task automatic cycle(input string tag, input bit w, input bit r0, input bit r1, input bit en);
        write_vs = w; read_0_vs = r0; read_1_vs = r1; enable = en;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic pulse(input string tag, input bit w, input bit r0, input bit r1);
        cycle(tag, w, r0, r1, 1'b1);
        cycle(tag, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        write_vs = 0; read_0_vs = 0; read_1_vs = 0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;
    endtask

    logic [1:0] saved_w, saved_r0, saved_r1;

    initial begin
        model_reset();
        @(negedge clk);
        enable = 1'b1;
        do_reset();

        // three write frames with no readers: writer avoids readers and latest
        for (int i = 0; i < 3; i++) pulse("w_only", 1, 0, 0);
        check("w_only_latest", 32'(latest_idx), 32'd1);
        check("w_only_write", 32'(write_idx), 32'd2);

        // reader 0 picks up the newest frame a few cycles later
        do_reset();
        pulse("w1", 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle("idle", 0, 0, 0, 1);
        pulse("r0", 0, 1, 0);
        check("r0_take", 32'(read_0_idx), 32'd1);
        check("r0_base", 32'(read_0_base), 32'(B1));
        pulse("w2", 1, 0, 0);

        // coincident write and reader edge: reader gets the just-finished frame
        saved_w = write_idx;
        pulse("w_r0", 1, 1, 0);
        check("coinc_r0", 32'(read_0_idx), 32'(saved_w));

        // build read_1 = 3, then assert reset asynchronously mid-frame
        do_reset();
        pulse("a1", 1, 0, 0);
        pulse("a2", 0, 1, 0);
        pulse("a3", 1, 0, 0);
        pulse("a4", 1, 0, 0);
        pulse("a5", 0, 0, 1);
        check("r1_is_3", 32'(read_1_idx), 32'd3);
        cycle("mid", 1, 0, 0, 1);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        write_vs = 0;
        @(negedge clk);
        rst = 1'b0;
        pulse("post_rst", 1, 0, 0);

        // disabled: vsync toggling is ignored, bases collapse to buffer 0
        saved_w = write_idx; saved_r0 = read_0_idx; saved_r1 = read_1_idx;
        for (int i = 0; i < 6; i++) cycle("dis", i[0], i[0], i[0], 0);
        check("dis_hold_w", 32'(write_idx), 32'(saved_w));
        check("dis_hold_r0", 32'(read_0_idx), 32'(saved_r0));
        check("dis_base_w", 32'(write_base), 32'(B0));
        cycle("dis_hi", 1, 0, 0, 0);
        // re-enable with write_vs already high: no edge until low then high
        cycle("reen_hi", 1, 0, 0, 1);
        check("reen_no_edge", 32'(write_idx), 32'(saved_w));
        cycle("reen_lo", 0, 0, 0, 1);
        cycle("reen_edge", 1, 0, 0, 1);

        // randomized vsync traffic
        for (int i = 0; i < 3000; i++) begin
            cycle("rnd", 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) != 0));
        end
        check("forced_seen", 32'(n_forced > 0), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
